// File: rtl/fetch_requester.sv
// Instruction-fetch initiator. Owns the PC, issues word reads to main memory, and registers
// each returned word into a one-entry valid/ready output register for decode.
//
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   mem_address           byte address to memory (always equals pc)
//   mem_read_write        constant 0 (read)
//   mem_data_in           constant 0 (never writes)
//   mem_data_out          combinational read data for mem_address
//   redirect_valid/_pc    one-cycle redirect pulse and target; flushes the output register
//   insn_valid/insn_ready output handshake; insn/insn_pc hold the word and its address
//   halted                fetch stopped (stop word, count limit or fault)
//   fault                 halted because of a misaligned or out-of-range PC
//   fetch_count           words loaded into the output register since reset (wraps)
module fetch_requester #(
  parameter logic [31:0] START_ADDR = 32'h01000000,
  parameter logic [31:0] MEM_BYTES  = 32'h00100000,
  parameter logic [31:0] STOP_WORD  = 32'h00000073,
  parameter logic [15:0] MAX_FETCH  = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetch_count
);

  typedef enum logic [0:0] {StFetch, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] insn_pc_q, insn_pc_d;
  logic        fault_q, fault_d;
  logic [15:0] count_q, count_d;

  logic        pc_legal;
  logic        redirect_legal;
  logic        load;
  logic [15:0] count_inc;

  // Word-aligned and inside [START_ADDR, START_ADDR+MEM_BYTES-4]; the offset form avoids
  // overflow of the upper bound.
  function automatic logic addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - START_ADDR;
    return (a[1:0] == 2'b00) && (a >= START_ADDR) && (off <= MEM_BYTES - 32'd4);
  endfunction

  assign pc_legal       = addr_ok(pc_q);
  assign redirect_legal = addr_ok(redirect_pc);
  assign load           = (state_q == StFetch) && pc_legal && (!valid_q || insn_ready) &&
                          !redirect_valid;
  assign count_inc      = count_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    insn_d    = insn_q;
    insn_pc_d = insn_pc_q;
    fault_d   = fault_q;
    count_d   = count_q;

    if (state_q == StFetch && redirect_valid) begin
      valid_d = 1'b0;
      if (redirect_legal) begin
        pc_d = redirect_pc;
      end else begin
        state_d = StHalt;
        fault_d = 1'b1;
      end
    end else if (state_q == StFetch && !pc_legal) begin
      // Held word stays presented; it drains through ready once in HALT.
      state_d = StHalt;
      fault_d = 1'b1;
    end else if (load) begin
      insn_d    = mem_data_out;
      insn_pc_d = pc_q;
      valid_d   = 1'b1;
      pc_d      = pc_q + 32'd4;
      count_d   = count_inc;
      if (mem_data_out == STOP_WORD || (MAX_FETCH != 16'd0 && count_inc == MAX_FETCH)) begin
        state_d = StHalt;
      end
    end else if (valid_q && insn_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= START_ADDR;
      valid_q   <= 1'b0;
      insn_q    <= 32'd0;
      insn_pc_q <= 32'd0;
      fault_q   <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      insn_q    <= insn_d;
      insn_pc_q <= insn_pc_d;
      fault_q   <= fault_d;
      count_q   <= count_d;
    end
  end

  assign mem_address    = pc_q;
  assign mem_read_write = 1'b0;
  assign mem_data_in    = 32'd0;
  assign insn_valid     = valid_q;
  assign insn           = insn_q;
  assign insn_pc        = insn_pc_q;
  assign halted         = (state_q == StHalt);
  assign fault          = fault_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_requester.sv
module tb_fetch_requester;

  logic        clock;
  logic        reset;
  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        halted;
  logic        fault;
  logic [15:0] fetch_count;

  int checks;
  int passes;

  // Memory model: word i at 0x01000000+4i holds 0x13 + 0x80*i; everything else reads 0.
  logic [31:0] mem [64];
  logic [31:0] off;

  always_comb begin
    off = mem_address - 32'h01000000;
    mem_data_out = (off < 32'd256) ? mem[off[7:2]] : 32'd0;
  end

  fetch_requester dut (
    .clock          (clock),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_read_write (mem_read_write),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn           (insn),
    .insn_pc        (insn_pc),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    insn_ready = 1'b1;
    do_reset();
    checks++; if (insn_valid !== 1'b0) $display("FAIL rst_valid got %h exp 0", insn_valid); else passes++;
    checks++; if (fetch_count !== 16'd0) $display("FAIL rst_count got %h exp 0", fetch_count); else passes++;
    checks++; if (mem_address !== 32'h01000000) $display("FAIL rst_addr got %h exp 01000000", mem_address); else passes++;
    checks++; if ({halted, fault} !== 2'b00) $display("FAIL rst_halt got %b exp 00", {halted, fault}); else passes++;
    checks++; if (insn !== 32'd0 || insn_pc !== 32'd0) $display("FAIL rst_insn got %h/%h exp 0/0", insn, insn_pc); else passes++;
    checks++; if (mem_read_write !== 1'b0 || mem_data_in !== 32'd0) $display("FAIL rst_memctl got %b/%h exp 0/0", mem_read_write, mem_data_in); else passes++;
  endtask

  // T1: three consecutive words at full throughput.
  task automatic test_stream();
    logic [31:0] exp_insn [3];
    exp_insn[0] = 32'h13; exp_insn[1] = 32'h93; exp_insn[2] = 32'h113;
    insn_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (insn_valid !== 1'b1 || insn !== exp_insn[i] || insn_pc !== 32'h01000000 + 32'(4 * i) ||
          fetch_count !== 16'(i + 1))
        $display("FAIL stream%0d got v=%b insn=%h pc=%h cnt=%0d exp v=1 insn=%h pc=%h cnt=%0d",
                 i, insn_valid, insn, insn_pc, fetch_count, exp_insn[i],
                 32'h01000000 + 32'(4 * i), i + 1);
      else passes++;
    end
  endtask

  // T2: stall holds the word and the PC; release loads the next word.
  task automatic test_stall();
    insn_ready = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (insn_valid !== 1'b1 || insn !== 32'h13 || mem_address !== 32'h01000004 || fetch_count !== 16'd1)
        $display("FAIL stall%0d got v=%b insn=%h addr=%h cnt=%0d exp v=1 insn=13 addr=01000004 cnt=1",
                 i, insn_valid, insn, mem_address, fetch_count);
      else passes++;
    end
    insn_ready = 1'b1;
    tick();
    checks++;
    if (insn_valid !== 1'b1 || insn !== 32'h93 || insn_pc !== 32'h01000004 || fetch_count !== 16'd2)
      $display("FAIL stall_release got v=%b insn=%h pc=%h cnt=%0d exp v=1 insn=93 pc=01000004 cnt=2",
               insn_valid, insn, insn_pc, fetch_count);
    else passes++;
  endtask

  // T3: redirect while stalled flushes, then fetches from the target.
  task automatic test_redirect();
    insn_ready = 1'b0;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h01000040;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (insn_valid !== 1'b0 || mem_address !== 32'h01000040)
      $display("FAIL redir_flush got v=%b addr=%h exp v=0 addr=01000040", insn_valid, mem_address);
    else passes++;
    insn_ready = 1'b1;
    tick();
    checks++;
    if (insn_valid !== 1'b1 || insn_pc !== 32'h01000040 || insn !== 32'h813 || fetch_count !== 16'd2)
      $display("FAIL redir_target got v=%b pc=%h insn=%h cnt=%0d exp v=1 pc=01000040 insn=813 cnt=2",
               insn_valid, insn_pc, insn, fetch_count);
    else passes++;
  endtask

  // T4: misaligned redirect faults; further redirects are ignored.
  task automatic test_bad_redirect();
    insn_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h01000042;
    tick();
    checks++;
    if ({halted, fault, insn_valid} !== 3'b110 || mem_address !== 32'h01000000)
      $display("FAIL misalign got h/f/v=%b addr=%h exp 110 addr=01000000", {halted, fault, insn_valid}, mem_address);
    else passes++;
    redirect_pc = 32'h01000040;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if ({halted, fault, insn_valid} !== 3'b110 || mem_address !== 32'h01000000 || fetch_count !== 16'd0)
      $display("FAIL halt_ignore got h/f/v=%b addr=%h cnt=%0d exp 110 addr=01000000 cnt=0",
               {halted, fault, insn_valid}, mem_address, fetch_count);
    else passes++;
  endtask

  // Last legal word is fetched; run-off past the top faults and the held word still drains.
  task automatic test_range_edge();
    insn_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h010FFFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (insn_valid !== 1'b1 || insn_pc !== 32'h010FFFFC || halted !== 1'b0 || fetch_count !== 16'd1)
      $display("FAIL top_word got v=%b pc=%h h=%b cnt=%0d exp v=1 pc=010ffffc h=0 cnt=1",
               insn_valid, insn_pc, halted, fetch_count);
    else passes++;
    tick();
    checks++;
    if ({halted, fault, insn_valid} !== 3'b111 || mem_address !== 32'h01100000)
      $display("FAIL runoff got h/f/v=%b addr=%h exp 111 addr=01100000", {halted, fault, insn_valid}, mem_address);
    else passes++;
    tick();
    checks++;
    if ({halted, fault, insn_valid} !== 3'b110 || fetch_count !== 16'd1)
      $display("FAIL halt_drain got h/f/v=%b cnt=%0d exp 110 cnt=1", {halted, fault, insn_valid}, fetch_count);
    else passes++;
  endtask

  // T5: stop word is presented, then fetch freezes. Ends with an async reset out of HALT.
  task automatic test_stop_word();
    mem[3] = 32'h00000073;
    insn_ready = 1'b1;
    do_reset();
    tick(); tick(); tick(); tick();
    checks++;
    if (insn_valid !== 1'b1 || insn !== 32'h73 || insn_pc !== 32'h0100000C || halted !== 1'b1 ||
        fault !== 1'b0 || mem_address !== 32'h01000010 || fetch_count !== 16'd4)
      $display("FAIL stop_word got v=%b insn=%h pc=%h h=%b f=%b addr=%h cnt=%0d exp 1 73 0100000c 1 0 01000010 4",
               insn_valid, insn, insn_pc, halted, fault, mem_address, fetch_count);
    else passes++;
    tick(); tick();
    checks++;
    if (insn_valid !== 1'b0 || halted !== 1'b1 || mem_address !== 32'h01000010 || fetch_count !== 16'd4)
      $display("FAIL stop_frozen got v=%b h=%b addr=%h cnt=%0d exp v=0 h=1 addr=01000010 cnt=4",
               insn_valid, halted, mem_address, fetch_count);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0 || mem_address !== 32'h01000000)
      $display("FAIL halt_async_rst got h=%b addr=%h exp h=0 addr=01000000", halted, mem_address);
    else passes++;
    mem[3] = 32'h193;
    tick();
    reset = 1'b0;
  endtask

  // T6: async reset mid-stall clears state without a clock edge; first word one edge later.
  task automatic test_async_reset();
    insn_ready = 1'b0;
    do_reset();
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (insn_valid !== 1'b0 || fetch_count !== 16'd0 || halted !== 1'b0 || mem_address !== 32'h01000000)
      $display("FAIL stall_async_rst got v=%b cnt=%0d h=%b addr=%h exp 0 0 0 01000000",
               insn_valid, fetch_count, halted, mem_address);
    else passes++;
    tick();
    reset = 1'b0;
    insn_ready = 1'b1;
    tick();
    checks++;
    if (insn_valid !== 1'b1 || insn_pc !== 32'h01000000 || fetch_count !== 16'd1)
      $display("FAIL post_rst_word got v=%b pc=%h cnt=%0d exp v=1 pc=01000000 cnt=1",
               insn_valid, insn_pc, fetch_count);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h13 + 32'(i * 32'h80);
    reset = 1'b1;
    insn_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_bad_redirect();
    test_range_edge();
    test_stop_word();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
